systolic_tile_scheduler: RTL and testbench

Sequences one K-length output tile through a ROWS x COLS systolic array of MAC PEs. Each PE forwards its input east and its weight south through one register stage. The block issues operand-buffer reads and generates skewed edge valids: row_valid_o goes to the west-edge input_valid, and col_valid_o goes to the north-edge weight_valid. It waits for the last beat to clear the array and the MAC pipeline, then pulses done_o. It sits between the tile-level command logic and the PE array.

---
 rtl/systolic_tile_scheduler.sv | 116 +++++++++++
 tb/tb_systolic_tile_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler: issues one K-deep tile into a ROWS x COLS systolic array with skewed edge valids (optional perf counters: SCHED_PERF_CNT_EN)
module systolic_tile_scheduler #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int K_WIDTH     = 11,
    parameter int K_MAX       = 1024,
    parameter int MAC_LATENCY = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [K_WIDTH-1:0] k_len_i,
    input  logic               stall_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               acc_clear_o,
    output logic               rd_en_o,
    output logic [K_WIDTH-1:0] rd_addr_o,
    output logic [ROWS-1:0]    row_valid_o,
    output logic [COLS-1:0]    col_valid_o
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        tile_cnt_o
`endif
);
    localparam int DRAIN_CYCLES = 1 + (ROWS - 1) + (COLS - 1) + MAC_LATENCY;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int SW = (ROWS > COLS) ? ROWS : COLS;

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [K_WIDTH-1:0] beat, klen, k_clamped;
    logic [DW-1:0]      drain;
    logic [SW-1:0]      skew;
    logic               last_beat;

    assign k_clamped   = (k_len_i > K_WIDTH'(K_MAX)) ? K_WIDTH'(K_MAX) : k_len_i;
    assign last_beat   = beat == klen - K_WIDTH'(1);
    assign rd_addr_o   = beat;
    assign row_valid_o = skew[ROWS-1:0];
    assign col_valid_o = skew[COLS-1:0];

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state and per-state outputs
    always_comb begin
        state_nx    = state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        acc_clear_o = 1'b0;
        rd_en_o     = 1'b0;
        case (state)
            IDLE:  if (start_i) state_nx = (k_len_i == '0) ? DONE : CLEAR;
            CLEAR: begin
                busy_o      = 1'b1;
                acc_clear_o = 1'b1;
                state_nx    = ISSUE;
            end
            ISSUE: begin
                busy_o  = 1'b1;
                rd_en_o = !stall_i;
                if (!stall_i && last_beat) state_nx = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (drain == '0) state_nx = DONE;
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // tile length latch, beat address (held on the last beat so it never passes klen-1) and drain countdown
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            klen  <= '0;
            beat  <= '0;
            drain <= '0;
        end else begin
            if (state == IDLE && start_i) klen <= k_clamped;
            if (state_nx == CLEAR) beat <= '0;
            else if (rd_en_o && !last_beat) beat <= beat + K_WIDTH'(1);
            if (rd_en_o && last_beat) drain <= DW'(DRAIN_CYCLES - 1);
            else if (state == DRAIN) drain <= drain - DW'(1);
        end
    end

    // skew line: bit 0 is the read-latency-delayed issue, bit n adds n more cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) skew <= '0;
        else       skew <= (skew << 1) | SW'(rd_en_o);
    end

`ifdef SCHED_PERF_CNT_EN
    // cumulative saturating stall and tile counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            tile_cnt_o  <= '0;
        end else begin
            if (state == ISSUE && stall_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (done_o && tile_cnt_o != '1) tile_cnt_o <= tile_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb_systolic_tile_scheduler: directed vector table plus reset and back-to-back sequences
module tb_systolic_tile_scheduler;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, stall_i;
    logic [10:0] k_len_i;
    logic        busy_o, done_o, acc_clear_o, rd_en_o;
    logic [10:0] rd_addr_o;
    logic [3:0]  row_valid_o, col_valid_o;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt_o, tile_cnt_o;
`endif

    systolic_tile_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i), .stall_i(stall_i),
        .busy_o(busy_o), .done_o(done_o), .acc_clear_o(acc_clear_o), .rd_en_o(rd_en_o),
        .rd_addr_o(rd_addr_o), .row_valid_o(row_valid_o), .col_valid_o(col_valid_o)
`ifdef SCHED_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .tile_cnt_o(tile_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int k, lo, hi, s2a, s2b;
        int clr, nclr, reads, last, done, busy, rv_first, rv3_last, rv0_cnt;
    } vec_t;

    vec_t v[6];
    int total = 0, bad = 0;
    int o_clr, o_nclr, o_reads, o_last, o_done, o_ndone, o_busy;
    int o_rv_first, o_rv3_last, o_rv0_cnt, o_extra, o_addr_err, o_skew_err;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_tile(input int k, input int lo, input int hi, input int s2a, input int s2b);
        logic [3:0] prev;
        prev = '0;
        o_clr = -1; o_nclr = 0; o_reads = 0; o_last = -1; o_done = -1; o_ndone = 0; o_busy = 0;
        o_rv_first = -1; o_rv3_last = -1; o_rv0_cnt = 0; o_extra = 0; o_addr_err = 0; o_skew_err = 0;
        for (int c = 0; c < 1200; c++) begin
            start_i = (c == 0) || (c == s2a) || (c == s2b);
            k_len_i = 11'(k);
            stall_i = (c >= lo) && (c <= hi);
            @(negedge clk_i);
            if (acc_clear_o) begin if (o_clr < 0) o_clr = c; o_nclr++; end
            if (rd_en_o) begin
                if (int'(rd_addr_o) != o_reads) o_addr_err++;
                o_last = int'(rd_addr_o);
                o_reads++;
            end
            if (busy_o) begin o_busy++; if (o_done >= 0) o_extra++; end
            if (done_o) begin if (o_done < 0) o_done = c; o_ndone++; end
            if (row_valid_o[0]) begin if (o_rv_first < 0) o_rv_first = c; o_rv0_cnt++; end
            if (row_valid_o[3]) o_rv3_last = c;
            if (row_valid_o != col_valid_o || row_valid_o[3:1] != prev[2:0]) o_skew_err++;
            prev = row_valid_o;
            @(posedge clk_i); #1;
            if (o_done >= 0 && c >= o_done + 4) break;
        end
        start_i = 1'b0;
        stall_i = 1'b0;
    endtask

    initial begin
        int nd, clr1, clr2, dn1, dn2, nclr;
        //        k    lo  hi  s2a  s2b   clr nclr reads last  done  busy rvf  rv3l  rv0n
        v[0] = '{4,    -1, -1, -1,  -1,    1,  1,   4,    3,   21,   20,  3,   9,    4};
        v[1] = '{4,     3,  4, -1,  -1,    1,  1,   4,    3,   23,   22,  3,   11,   4};
        v[2] = '{0,    -1, -1, -1,  -1,   -1,  0,   0,   -1,    1,    0, -1,   -1,   0};
        v[3] = '{2000, -1, -1, 10,  1041,  1,  1,   1024, 1023, 1041, 1040, 3,  1029, 1024};
        v[4] = '{1,    -1, -1, -1,  -1,    1,  1,   1,    0,   18,   17,  3,   6,    1};
        v[5] = '{3,     2,  2, -1,  -1,    1,  1,   3,    2,   21,   20,  4,   9,    3};

        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; k_len_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_clear", int'(acc_clear_o), 0);
        check("rst_rd_en", int'(rd_en_o), 0);
        check("rst_addr", int'(rd_addr_o), 0);
        check("rst_row_valid", int'(row_valid_o), 0);
        check("rst_col_valid", int'(col_valid_o), 0);
        @(posedge clk_i); #1;

        for (int i = 0; i < 6; i++) begin
            run_tile(v[i].k, v[i].lo, v[i].hi, v[i].s2a, v[i].s2b);
            check($sformatf("v%0d_clear_cycle", i), o_clr, v[i].clr);
            check($sformatf("v%0d_clear_count", i), o_nclr, v[i].nclr);
            check($sformatf("v%0d_reads", i), o_reads, v[i].reads);
            check($sformatf("v%0d_last_addr", i), o_last, v[i].last);
            check($sformatf("v%0d_done_cycle", i), o_done, v[i].done);
            check($sformatf("v%0d_busy_cycles", i), o_busy, v[i].busy);
            check($sformatf("v%0d_row0_first", i), o_rv_first, v[i].rv_first);
            check($sformatf("v%0d_row3_last", i), o_rv3_last, v[i].rv3_last);
            check($sformatf("v%0d_row0_count", i), o_rv0_cnt, v[i].rv0_cnt);
            check($sformatf("v%0d_done_pulses", i), o_ndone, 1);
            check($sformatf("v%0d_busy_after_done", i), o_extra, 0);
            check($sformatf("v%0d_addr_order", i), o_addr_err, 0);
            check($sformatf("v%0d_skew", i), o_skew_err, 0);
        end

        start_i = 1'b1; k_len_i = 11'd8;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) begin @(posedge clk_i); #1; end
        @(negedge clk_i);
        check("midrst_pre_rd_en", int'(rd_en_o), 1);
        check("midrst_pre_addr", int'(rd_addr_o), 2);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_rd_en", int'(rd_en_o), 0);
        check("midrst_addr", int'(rd_addr_o), 0);
        check("midrst_clear", int'(acc_clear_o), 0);
        check("midrst_row_valid", int'(row_valid_o), 0);
        check("midrst_col_valid", int'(col_valid_o), 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done_o || busy_o) nd++;
        end
        check("midrst_no_done", nd, 0);
        @(posedge clk_i); #1;
        run_tile(1, -1, -1, -1, -1);
        check("after_rst_done_cycle", o_done, 18);
        check("after_rst_reads", o_reads, 1);
        check("after_rst_last_addr", o_last, 0);

        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        clr1 = -1; clr2 = -1; dn1 = -1; dn2 = -1; nd = 0; nclr = 0;
        for (int c = 0; c <= 50; c++) begin
            start_i = c <= 30;
            stall_i = (c == 2) || (c == 10);
            k_len_i = 11'd2;
            @(negedge clk_i);
            if (acc_clear_o) begin if (nclr == 0) clr1 = c; else clr2 = c; nclr++; end
            if (done_o) begin if (nd == 0) dn1 = c; else dn2 = c; nd++; end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0; stall_i = 1'b0;
        check("b2b_clear1", clr1, 1);
        check("b2b_done1", dn1, 20);
        check("b2b_clear2", clr2, 22);
        check("b2b_done2", dn2, 40);
        check("b2b_done_count", nd, 2);
        check("b2b_clear_count", nclr, 2);
`ifdef SCHED_PERF_CNT_EN
        check("perf_tile_cnt", int'(tile_cnt_o), 2);
        check("perf_stall_cnt", int'(stall_cnt_o), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
